// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags. Holds committed
// values, tracks the youngest pending ROB producer per register, and serves
// issue-time operands as either a ready value or a pending tag.
module reg_file #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int ROB_ID_WIDTH = 4,
  localparam int IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reset_from_rob_bus,
  input  logic                    valid_from_issuer,
  input  logic [IDX_W-1:0]        rs1_from_issuer,
  input  logic [IDX_W-1:0]        rs2_from_issuer,
  input  logic [IDX_W-1:0]        rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [XLEN-1:0]         vj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [XLEN-1:0]         vk_to_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [IDX_W-1:0]        rd_from_rob,
  input  logic [XLEN-1:0]         value_from_rob
);

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] q;
    logic [XLEN-1:0]         v;
  } operand_t;

  logic [XLEN-1:0]         value [NUM_REGS];
  logic [ROB_ID_WIDTH-1:0] tag   [NUM_REGS];

  logic     commit_en;
  logic     rename_en;
  operand_t op_j;
  operand_t op_k;

  // Commit/rename only count when the state would actually update this cycle,
  // so the bypass never forwards a commit that is being stalled by rdy.
  assign commit_en = rdy && !rst && (dest_from_rob != '0) && (rd_from_rob != '0);
  assign rename_en = valid_from_issuer && !reset_from_rob_bus && (rd_from_issuer != '0);

  function automatic operand_t lookup(input logic [IDX_W-1:0]        rs,
                                      input logic [ROB_ID_WIDTH-1:0] rs_tag,
                                      input logic [XLEN-1:0]         rs_value);
    operand_t op;
    if (rs == '0) begin
      op = '0;
    end else if (rs_tag == '0) begin
      op = '{q: '0, v: rs_value};
    end else if (commit_en && (rd_from_rob == rs) && (dest_from_rob == rs_tag)) begin
      op = '{q: '0, v: value_from_rob};
    end else begin
      op = '{q: rs_tag, v: '0};
    end
    return op;
  endfunction

  // NOTE: every always_comb output gets a value on every path here (the
  // function returns a fully assigned struct), so no latch can be inferred.
  always_comb begin
    op_j = lookup(rs1_from_issuer, tag[rs1_from_issuer], value[rs1_from_issuer]);
    op_k = lookup(rs2_from_issuer, tag[rs2_from_issuer], value[rs2_from_issuer]);
  end

  assign qj_to_issuer = op_j.q;
  assign vj_to_issuer = op_j.v;
  assign qk_to_issuer = op_k.q;
  assign vk_to_issuer = op_k.v;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the value array is reset explicitly because a reset must read as
  // all-zero operands; this makes it flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit_en && (rd_from_rob == IDX_W'(i))) begin
          value[i] <= value_from_rob;
        end
        // Tag priority: flush > rename > commit clear.
        if (reset_from_rob_bus) begin
          tag[i] <= '0;
        end else if (rename_en && (rd_from_issuer == IDX_W'(i))) begin
          tag[i] <= dest_from_issuer;
        end else if (commit_en && (rd_from_rob == IDX_W'(i)) && (tag[i] == dest_from_rob)) begin
          tag[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, x0, rename, commit bypass,
// stale commit masking, same-cycle rename/commit, flush, rdy stall and reset.
module tb_reg_file;

  localparam int XLEN = 32;
  localparam int RW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            reset_from_rob_bus;
  logic            valid_from_issuer;
  logic [4:0]      rs1_from_issuer;
  logic [4:0]      rs2_from_issuer;
  logic [4:0]      rd_from_issuer;
  logic [RW-1:0]   dest_from_issuer;
  logic [RW-1:0]   qj_to_issuer;
  logic [XLEN-1:0] vj_to_issuer;
  logic [RW-1:0]   qk_to_issuer;
  logic [XLEN-1:0] vk_to_issuer;
  logic [RW-1:0]   dest_from_rob;
  logic [4:0]      rd_from_rob;
  logic [XLEN-1:0] value_from_rob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .reset_from_rob_bus (reset_from_rob_bus),
    .valid_from_issuer  (valid_from_issuer),
    .rs1_from_issuer    (rs1_from_issuer),
    .rs2_from_issuer    (rs2_from_issuer),
    .rd_from_issuer     (rd_from_issuer),
    .dest_from_issuer   (dest_from_issuer),
    .qj_to_issuer       (qj_to_issuer),
    .vj_to_issuer       (vj_to_issuer),
    .qk_to_issuer       (qk_to_issuer),
    .vk_to_issuer       (vk_to_issuer),
    .dest_from_rob      (dest_from_rob),
    .rd_from_rob        (rd_from_rob),
    .value_from_rob     (value_from_rob)
  );

  task automatic check(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    valid_from_issuer  = 1'b0;
    rd_from_issuer     = '0;
    dest_from_issuer   = '0;
    dest_from_rob      = '0;
    rd_from_rob        = '0;
    value_from_rob     = '0;
    reset_from_rob_bus = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [RW-1:0] t);
    valid_from_issuer = 1'b1;
    rd_from_issuer    = rd;
    dest_from_issuer  = t;
  endtask

  task automatic commit(input logic [RW-1:0] t, input logic [4:0] rd, input logic [XLEN-1:0] v);
    dest_from_rob  = t;
    rd_from_rob    = rd;
    value_from_rob = v;
  endtask

  // Drive rs1 (port 0) or rs2 (port 1), settle, compare q and v.
  task automatic expect_op(input string name, input bit port, input logic [4:0] rs,
                           input logic [RW-1:0] q, input logic [XLEN-1:0] v);
    if (port == 1'b0) rs1_from_issuer = rs;
    else              rs2_from_issuer = rs;
    #1;
    if (port == 1'b0) begin
      check({name, ".qj"}, XLEN'(qj_to_issuer), XLEN'(q));
      check({name, ".vj"}, vj_to_issuer, v);
    end else begin
      check({name, ".qk"}, XLEN'(qk_to_issuer), XLEN'(q));
      check({name, ".vk"}, vk_to_issuer, v);
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b0;
    rs1_from_issuer = '0;
    rs2_from_issuer = '0;
    clear_ops();
    tick();
    tick();
    rst = 1'b0;
    rdy = 1'b1;

    // Reset state and x0.
    expect_op("reset_rs1_x5", 1'b0, 5'd5, '0, '0);
    expect_op("reset_rs2_x0", 1'b1, 5'd0, '0, '0);
    commit(4'd1, 5'd0, 32'h55);
    tick();
    clear_ops();
    expect_op("x0_after_commit", 1'b0, 5'd0, '0, '0);

    // Rename, then commit with same-cycle bypass, then from state.
    rename(5'd3, 4'd2);
    tick();
    clear_ops();
    expect_op("x3_renamed", 1'b0, 5'd3, 4'd2, '0);
    commit(4'd2, 5'd3, 32'hDEAD);
    expect_op("x3_bypass", 1'b0, 5'd3, '0, 32'hDEAD);
    expect_op("x3_bypass_rs2", 1'b1, 5'd3, '0, 32'hDEAD);
    tick();
    clear_ops();
    expect_op("x3_committed", 1'b0, 5'd3, '0, 32'hDEAD);

    // Stale commit does not clear a younger tag.
    rename(5'd4, 4'd1);
    tick();
    rename(5'd4, 4'd3);
    tick();
    clear_ops();
    commit(4'd1, 5'd4, 32'd7);
    expect_op("x4_stale_no_bypass", 1'b0, 5'd4, 4'd3, '0);
    tick();
    clear_ops();
    expect_op("x4_masked", 1'b1, 5'd4, 4'd3, '0);

    // Same-cycle rename and commit on x6: read sees older producer (bypass).
    rename(5'd6, 4'd4);
    tick();
    clear_ops();
    rename(5'd6, 4'd5);
    commit(4'd4, 5'd6, 32'h66);
    expect_op("x6_same_cycle_read", 1'b0, 5'd6, '0, 32'h66);
    tick();
    clear_ops();
    expect_op("x6_rename_wins", 1'b0, 5'd6, 4'd5, '0);

    // Flush with concurrent commit and rename.
    rename(5'd1, 4'd1);
    tick();
    rename(5'd2, 4'd2);
    tick();
    clear_ops();
    expect_op("x2_pending", 1'b1, 5'd2, 4'd2, '0);
    reset_from_rob_bus = 1'b1;
    commit(4'd1, 5'd1, 32'd9);
    rename(5'd7, 4'd3);
    tick();
    clear_ops();
    expect_op("flush_x1", 1'b0, 5'd1, '0, 32'd9);
    expect_op("flush_x2", 1'b1, 5'd2, '0, '0);
    expect_op("flush_x7", 1'b0, 5'd7, '0, '0);
    expect_op("flush_x4", 1'b1, 5'd4, '0, 32'd7);
    expect_op("flush_x6", 1'b0, 5'd6, '0, 32'h66);

    // rdy low freezes state; rst with rdy low still clears.
    rename(5'd9, 4'd7);
    tick();
    clear_ops();
    expect_op("x9_renamed", 1'b0, 5'd9, 4'd7, '0);
    rdy = 1'b0;
    rename(5'd5, 4'd6);
    commit(4'd1, 5'd3, 32'h1234);
    expect_op("stall_no_bypass", 1'b1, 5'd3, '0, 32'hDEAD);
    tick();
    clear_ops();
    expect_op("stall_x3", 1'b0, 5'd3, '0, 32'hDEAD);
    expect_op("stall_x5", 1'b1, 5'd5, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    expect_op("rst_x3", 1'b0, 5'd3, '0, '0);
    expect_op("rst_x9", 1'b1, 5'd9, '0, '0);
    expect_op("rst_x1", 1'b0, 5'd1, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer's commit port and beside the issuer's operand lookup. It holds committed register values. It records which ROB entry will next produce each register, and serves each issuing instruction's two source operands as either a ready value or a pending ROB tag. On a ROB flush it discards all rename state and keeps the committed values.

## Interface
- XLEN, 32, register data width
- NUM_REGS, 32, architectural register count; index width is log2(NUM_REGS)
- ROB_ID_WIDTH, 4, ROB tag width; tag 0 means "no producer / invalid"
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous and active-high
- rdy  in  1  global enable; when low, no state changes
- reset_from_rob_bus  in  1  mispredict flush from ROB
- valid_from_issuer  in  1  an instruction is issued this cycle
- rs1_from_issuer  in  5  source register 1 index
- rs2_from_issuer  in  5  source register 2 index
- rd_from_issuer  in  5  destination register index
- dest_from_issuer  in  ROB_ID_WIDTH  ROB tag allocated to the issued instruction
- qj_to_issuer  out  ROB_ID_WIDTH  pending tag for rs1; 0 means vj is valid
- vj_to_issuer  out  XLEN  rs1 value
- qk_to_issuer  out  ROB_ID_WIDTH  pending tag for rs2; 0 means vk is valid
- vk_to_issuer  out  XLEN  rs2 value
- dest_from_rob  in  ROB_ID_WIDTH  committing ROB tag; 0 means no commit this cycle
- rd_from_rob  in  5  committing destination register
- value_from_rob  in  XLEN  committing value

## Operation
- State: value[NUM_REGS] (XLEN bits) and tag[NUM_REGS] (ROB_ID_WIDTH bits).
- Register x0 reads as value 0 and tag 0. Renames and commits that target x0 are ignored.
- Commit: when dest_from_rob != 0 and rd_from_rob != 0:
  - value[rd_from_rob] <= value_from_rob.
  - If tag[rd_from_rob] == dest_from_rob, then tag[rd_from_rob] <= 0. Otherwise the tag is kept, because a younger producer is still pending.
- Rename: when valid_from_issuer and rd_from_issuer != 0, tag[rd_from_issuer] <= dest_from_issuer.
- Same register renamed and committed in the same cycle: the rename tag wins. The value write still happens.
- Operand read is combinational, for rs1 (giving qj/vj) and likewise for rs2 (giving qk/vk):
  - If tag[rs] == 0: q = 0 and v = value[rs].
  - Else, if a commit is active with rd_from_rob == rs and dest_from_rob == tag[rs] (commit bypass): q = 0 and v = value_from_rob.
  - Else: q = tag[rs] and v = 0.
- Reads reflect state before the same cycle's rename. An instruction whose source equals its own rd sees the older producer.
- Flush (reset_from_rob_bus = 1, rst = 0, rdy = 1):
  - All tags are cleared to 0.
  - A commit in the same cycle still writes its value.
  - A rename in the same cycle is ignored.
- rst = 1 clears all values and tags to 0. rst overrides everything, including rdy.
- rdy = 0 (rst = 0): all state holds. Outputs remain combinational on the current state.

## Timing
- Operand outputs: zero-cycle latency, with no registered outputs. They are therefore well defined from the first cycle after reset (all q = 0, all v = 0).
- A commit or rename becomes visible in the state on the next cycle. The commit bypass makes a commit visible in the same cycle.
- Every cycle accepts one rename and one commit concurrently. There is no backpressure; the issuer stalls on ROB full.
- Priority per register, per cycle: rst > flush (clears tags) > rename > commit tag-clear. The commit value write is independent of tag priority.
- Flush asserted mid-stream: renames issued on the flush cycle are dropped. Issue resumes on the next cycle with all operands ready.

## Test plan
- Reset, then read rs1 = 5 and rs2 = 0 → qj = 0, vj = 0, qk = 0, vk = 0. Commit rd = 0 with value 0x55 → x0 still reads 0.
- Rename x3 to tag 2 → the next cycle reads qj = 2, vj = 0. Commit dest 2, rd 3, value 0xDEAD → the same cycle reads qj = 0, vj = 0xDEAD via bypass; the following cycle reads tag 0 with the value from state.
- Rename x4 to tag 1, then rename x4 to tag 3. Commit dest 1, rd 4, value 7 → x4 reads qj = 3; value[4] = 7 is stored but masked.
- Same cycle: rename x6 to tag 5 and commit dest 4, rd 6 (where tag[6] = 4) → next cycle tag[6] = 5 and value[6] = committed value.
- Rename x1 to tag 1 and x2 to tag 2, then assert flush together with commit dest 1, rd 1, value 9 and rename x7 to tag 3 → next cycle all tags are 0, x1 = 9, x7 is not renamed.
- Hold rdy = 0 while driving rename and commit → no state change. Then assert rst with rdy = 0 → all values and tags read 0 the next cycle.
